// File: rtl/adc_sampler_pkg.sv
// Shared types and constants for the battery-monitor ADC conversion controller.
package adc_sampler_pkg;

    localparam int unsigned ADC_W = 12;
    localparam logic [2:0] DEFAULT_CHANNEL = 3'b001;

    typedef enum logic [1:0] {
        StIdle,
        StSoc,
        StWait,
        StAcc
    } state_e;

endpackage

// File: rtl/adc_sampler_if.sv
// Bundle of ADC handshake, request and averaged-result signals around adc_sampler.
interface adc_sampler_if;
    import adc_sampler_pkg::*;

    logic             enable;
    logic             adc_soc;
    logic [2:0]       adc_s;
    logic             adc_eoc;
    logic [ADC_W-1:0] adc_dout;
    logic [ADC_W-1:0] avg_value;
    logic             avg_valid;
    logic             busy;
    logic             err_timeout;

    // master: the conversion controller; slave: the ADC macro and downstream consumer
    modport master (
        input  enable, adc_eoc, adc_dout,
        output adc_soc, adc_s, avg_value, avg_valid, busy, err_timeout
    );

    modport slave (
        output enable, adc_eoc, adc_dout,
        input  adc_soc, adc_s, avg_value, avg_valid, busy, err_timeout
    );

endinterface

// File: rtl/adc_sampler_sync_edge.sv
// Two-flop synchroniser with rising-edge detect for an asynchronous strobe.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/adc_sampler.sv
// ADC conversion controller: SOC pulses, EOC sync, capture and 2^AVG_LOG2 averaging.
// Optional EOC watchdog enabled by defining ADC_SAMPLER_TIMEOUT_EN.
module adc_sampler
    import adc_sampler_pkg::*;
#(
    parameter logic [2:0]  CHANNEL     = DEFAULT_CHANNEL,
    parameter int unsigned AVG_LOG2    = 3,
    parameter int unsigned SOC_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input logic            osc_clk,
    input logic            rst_n,
    adc_sampler_if.master  bus
);

    localparam int unsigned AccW = ADC_W + AVG_LOG2;
    localparam int unsigned CntW = AVG_LOG2 + 1;
    localparam int unsigned SocW = $clog2(SOC_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'((1 << AVG_LOG2) - 1);
    localparam logic [SocW-1:0] SocLast = SocW'(SOC_CYCLES - 1);

    state_e           state_q;
    logic [AccW-1:0]  acc_q;
    logic [CntW-1:0]  cnt_q;
    logic [SocW-1:0]  soc_cnt_q;
    logic             soc_q;
    logic [ADC_W-1:0] avg_q;
    logic             valid_q;
    logic             eoc_rise;

`ifdef ADC_SAMPLER_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYC - 1);
    logic [ToW-1:0] to_cnt_q;
    logic           err_q;
`endif

    sync_edge u_eoc_sync (
        .clk      (osc_clk),
        .rst_n    (rst_n),
        .async_in (bus.adc_eoc),
        .rise     (eoc_rise)
    );

    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            cnt_q     <= '0;
            soc_cnt_q <= '0;
            soc_q     <= 1'b0;
            avg_q     <= '0;
            valid_q   <= 1'b0;
`ifdef ADC_SAMPLER_TIMEOUT_EN
            to_cnt_q  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.enable) begin
                        state_q   <= StSoc;
                        soc_q     <= 1'b1;
                        soc_cnt_q <= '0;
                    end
                end
                StSoc: begin
                    if (soc_cnt_q == SocLast) begin
                        soc_q   <= 1'b0;
                        state_q <= StWait;
`ifdef ADC_SAMPLER_TIMEOUT_EN
                        to_cnt_q <= '0;
`endif
                    end else begin
                        soc_cnt_q <= soc_cnt_q + SocW'(1);
                    end
                end
                StWait: begin
                    if (eoc_rise) begin
                        acc_q   <= acc_q + AccW'(bus.adc_dout);
                        state_q <= StAcc;
                    end
`ifdef ADC_SAMPLER_TIMEOUT_EN
                    // A lost EOC abandons the partial average; IDLE restarts if enable holds.
                    else if (to_cnt_q == ToLast) begin
                        err_q   <= 1'b1;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        to_cnt_q <= to_cnt_q + ToW'(1);
                    end
`endif
                end
                StAcc: begin
                    if (cnt_q == CntLast) begin
                        avg_q   <= ADC_W'(acc_q >> AVG_LOG2);
                        valid_q <= 1'b1;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end else if (!bus.enable) begin
                        acc_q <= '0;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                    if (bus.enable) begin
                        state_q   <= StSoc;
                        soc_q     <= 1'b1;
                        soc_cnt_q <= '0;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.adc_s     = CHANNEL;
    assign bus.adc_soc   = soc_q;
    assign bus.avg_value = avg_q;
    assign bus.avg_valid = valid_q;
    assign bus.busy      = (state_q != StIdle);
`ifdef ADC_SAMPLER_TIMEOUT_EN
    assign bus.err_timeout = err_q;
`else
    assign bus.err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_adc_sampler.sv
// Directed bench for adc_sampler: averaging table, latency, enable drop, timeout, reset.
module tb_adc_sampler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    adc_sampler_if bus ();
    adc_sampler_if bus0 ();

    adc_sampler #(
        .CHANNEL     (3'b001),
        .AVG_LOG2    (2),
        .SOC_CYCLES  (4),
        .TIMEOUT_CYC (16)
    ) dut (
        .osc_clk (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    adc_sampler #(
        .CHANNEL     (3'b001),
        .AVG_LOG2    (0),
        .SOC_CYCLES  (2),
        .TIMEOUT_CYC (1024)
    ) dut0 (
        .osc_clk (clk),
        .rst_n   (rst_n),
        .bus     (bus0)
    );

    int checks = 0;
    int failures = 0;

    int soc_pulses = 0;
    int soc_bad = 0;
    int soc_run = 0;
    int valid_cnt = 0;
    int valid_long = 0;
    int busy_cycles = 0;
    logic [11:0] last_avg = '0;
    bit prev_valid = 1'b0;

    always @(negedge clk) begin
        if (bus.adc_soc) begin
            soc_run++;
        end else if (soc_run != 0) begin
            soc_pulses++;
            if (soc_run != 4) soc_bad++;
            soc_run = 0;
        end
        if (bus.avg_valid) begin
            valid_cnt++;
            last_avg = bus.avg_value;
            if (prev_valid) valid_long++;
        end
        prev_valid = bus.avg_valid;
        if (bus.busy) busy_cycles++;
    end

    typedef struct {
        logic [3:0][11:0] d;
        logic [11:0]      exp;
    } vec_t;

    vec_t vecs[6];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic wait_soc_done();
        int n;
        n = 0;
        while (!bus.adc_soc && n < 200) begin
            tick(1);
            n++;
        end
        if (!bus.adc_soc) bound_fail("soc_rise");
        n = 0;
        while (bus.adc_soc && n < 200) begin
            tick(1);
            n++;
        end
        if (bus.adc_soc) bound_fail("soc_fall");
    endtask

    task automatic eoc_pulse(input logic [11:0] d, input bit drop_en);
        tick(2);
        bus.adc_dout = d;
        bus.adc_eoc  = 1'b1;
        if (drop_en) bus.enable = 1'b0;
        tick(5);
        bus.adc_eoc = 1'b0;
        tick(1);
    endtask

    task automatic convert(input logic [11:0] d, input bit drop_en);
        wait_soc_done();
        eoc_pulse(d, drop_en);
    endtask

    initial begin
        int s_soc, s_bad, s_val, n;

        vecs[0] = '{d: {12'd401, 12'd300, 12'd200, 12'd100}, exp: 12'd250};
        vecs[1] = '{d: {12'd3, 12'd0, 12'd0, 12'd0}, exp: 12'd0};
        vecs[2] = '{d: {12'd4095, 12'd4095, 12'd4095, 12'd4095}, exp: 12'd4095};
        vecs[3] = '{d: {12'd4, 12'd3, 12'd2, 12'd1}, exp: 12'd2};
        vecs[4] = '{d: {12'd0, 12'd4095, 12'd0, 12'd4095}, exp: 12'd2047};
        vecs[5] = '{d: {12'd6, 12'd7, 12'd7, 12'd7}, exp: 12'd6};

        bus.enable = 1'b0;
        bus.adc_eoc = 1'b0;
        bus.adc_dout = '0;
        bus0.enable = 1'b0;
        bus0.adc_eoc = 1'b0;
        bus0.adc_dout = '0;

        // Reset values
        tick(3);
        check("rst_soc", 32'(bus.adc_soc), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_valid", 32'(bus.avg_valid), 0);
        check("rst_value", 32'(bus.avg_value), 0);
        check("rst_err", 32'(bus.err_timeout), 0);
        check("chan", 32'(bus.adc_s), 1);
        check("chan0", 32'(bus0.adc_s), 1);
        rst_n = 1'b1;

        // Idle for 100 clocks
        tick(100);
        check("idle_busy_cycles", 32'(busy_cycles), 0);
        check("idle_valid_cnt", 32'(valid_cnt), 0);
        check("idle_soc_pulses", 32'(soc_pulses), 0);
        check("idle_soc", 32'(bus.adc_soc), 0);
        check("idle_value", 32'(bus.avg_value), 0);

        // Averaging table
        for (int v = 0; v < 6; v++) begin
            s_soc = soc_pulses;
            s_bad = soc_bad;
            s_val = valid_cnt;
            bus.enable = 1'b1;
            for (int i = 0; i < 4; i++) convert(vecs[v].d[i], i == 3);
            tick(4);
            check($sformatf("vec%0d_valid_cnt", v), 32'(valid_cnt - s_val), 1);
            check($sformatf("vec%0d_avg", v), 32'(last_avg), 32'(vecs[v].exp));
            check($sformatf("vec%0d_soc_pulses", v), 32'(soc_pulses - s_soc), 4);
            check($sformatf("vec%0d_soc_width", v), 32'(soc_bad - s_bad), 0);
        end

        // Latency on the single-sample instance
        bus0.enable = 1'b1;
        n = 0;
        while (!bus0.adc_soc && n < 50) begin tick(1); n++; end
        while (bus0.adc_soc && n < 100) begin tick(1); n++; end
        if (n >= 100) bound_fail("lat_soc");
        tick(2);
        bus0.adc_dout = 12'hABC;
        bus0.adc_eoc = 1'b1;
        bus0.enable = 1'b0;
        tick(3);
        check("lat_t3_valid", 32'(bus0.avg_valid), 0);
        check("lat_t3_busy", 32'(bus0.busy), 1);
        tick(1);
        check("lat_t4_valid", 32'(bus0.avg_valid), 1);
        check("lat_t4_value", 32'(bus0.avg_value), 32'h0ABC);
        tick(1);
        check("lat_t5_valid", 32'(bus0.avg_valid), 0);
        check("lat_t5_busy", 32'(bus0.busy), 0);
        bus0.adc_eoc = 1'b0;

        // Enable dropped after the 2nd sample
        s_soc = soc_pulses;
        s_val = valid_cnt;
        bus.enable = 1'b1;
        convert(12'd1000, 1'b0);
        convert(12'd2000, 1'b0);
        bus.enable = 1'b0;
        convert(12'd3000, 1'b0);
        tick(4);
        check("drop_busy", 32'(bus.busy), 0);
        check("drop_valid_cnt", 32'(valid_cnt - s_val), 0);
        check("drop_soc_pulses", 32'(soc_pulses - s_soc), 3);
        s_val = valid_cnt;
        bus.enable = 1'b1;
        convert(12'd8, 1'b0);
        convert(12'd8, 1'b0);
        convert(12'd8, 1'b0);
        convert(12'd12, 1'b1);
        tick(2);
        check("reen_valid_cnt", 32'(valid_cnt - s_val), 1);
        check("reen_avg", 32'(last_avg), 9);

`ifdef ADC_SAMPLER_TIMEOUT_EN
        bus.enable = 1'b1;
        wait_soc_done();
        tick(15);
        check("to_w15_err", 32'(bus.err_timeout), 0);
        tick(1);
        check("to_w16_err", 32'(bus.err_timeout), 1);
        check("to_w16_busy", 32'(bus.busy), 0);
        tick(1);
        check("to_resoc", 32'(bus.adc_soc), 1);
        bus.enable = 1'b0;
        tick(40);
        check("to_sticky", 32'(bus.err_timeout), 1);
        check("to_idle", 32'(bus.busy), 0);
`else
        bus.enable = 1'b1;
        wait_soc_done();
        tick(40);
        check("nto_err", 32'(bus.err_timeout), 0);
        check("nto_wait_busy", 32'(bus.busy), 1);
        eoc_pulse(12'd0, 1'b1);
        tick(3);
        check("nto_idle", 32'(bus.busy), 0);
`endif

        // Reset during WAIT, then stale EOC after release
        bus.enable = 1'b1;
        wait_soc_done();
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_soc", 32'(bus.adc_soc), 0);
        check("arst_busy", 32'(bus.busy), 0);
        check("arst_value", 32'(bus.avg_value), 0);
        check("arst_valid", 32'(bus.avg_valid), 0);
        check("arst_err", 32'(bus.err_timeout), 0);
        bus.adc_dout = 12'd3000;
        bus.adc_eoc = 1'b1;
        tick(2);
        rst_n = 1'b1;
        s_soc = soc_pulses;
        s_val = valid_cnt;
        tick(10);
        check("stale_soc_pulses", 32'(soc_pulses - s_soc), 1);
        check("stale_busy", 32'(bus.busy), 1);
        check("stale_valid_cnt", 32'(valid_cnt - s_val), 0);
        bus.adc_eoc = 1'b0;
        eoc_pulse(12'd40, 1'b0);
        convert(12'd40, 1'b0);
        convert(12'd40, 1'b0);
        convert(12'd44, 1'b1);
        tick(2);
        check("post_rst_valid_cnt", 32'(valid_cnt - s_val), 1);
        check("post_rst_avg", 32'(last_avg), 41);

        check("valid_single_cycle", 32'(valid_long), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
